elem_array_packer: RTL and testbench

//  Upstream feeder for the 4-element array rearrangement stage (slice/index/concat network).

---
 rtl/elem_array_packer.sv | 139 +++++++++++++
 tb/tb_elem_array_packer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elem_array_packer.sv
// Packs a serial stream of {flag, payload} tuples into a registered 4-element array.
// Optional partial-group flush (ports flush, out_cnt) is enabled by defining PACKER_FLUSH_EN.
module elem_array_packer #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in__0,
  input  logic [DATA_W-1:0] in__1,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PACKER_FLUSH_EN
  input  logic              flush,
  output logic [2:0]        out_cnt,
`endif
  output logic              out_0__0,
  output logic [DATA_W-1:0] out_0__1,
  output logic              out_1__0,
  output logic [DATA_W-1:0] out_1__1,
  output logic              out_2__0,
  output logic [DATA_W-1:0] out_2__1,
  output logic              out_3__0,
  output logic [DATA_W-1:0] out_3__1
);

  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        fill_flag_q, fill_flag_d;
  logic [DATA_W-1:0] fill_pay_q [4];
  logic [DATA_W-1:0] fill_pay_d [4];
  logic [3:0]        out_flag_q, out_flag_d;
  logic [DATA_W-1:0] out_pay_q [4];
  logic [DATA_W-1:0] out_pay_d [4];
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              out_free;
  logic              flush_req;
  logic              fire;
  logic [2:0]        eff_cnt;
  logic [3:0]        stage_flag;
  logic [DATA_W-1:0] stage_pay [4];

`ifdef PACKER_FLUSH_EN
  logic       flush_pend_q, flush_pend_d;
  logic [2:0] out_cnt_q, out_cnt_d;

  assign flush_req = flush || flush_pend_q;
  assign in_ready  = !arst && (cnt_q != 3'd4) && !flush_pend_q;
  assign out_cnt   = out_cnt_q;
`else
  assign flush_req = 1'b0;
  assign in_ready  = !arst && (cnt_q != 3'd4);
`endif

  always_comb begin
    accept   = in_valid && in_ready;
    out_free = !out_valid_q || out_ready;
    eff_cnt  = cnt_q + {2'b00, accept};

    // Fill buffer as it would look with this cycle's tuple included; the output
    // loads from here so the 4th tuple can bypass straight into the array.
    for (int i = 0; i < 4; i++) begin
      stage_flag[i] = fill_flag_q[i];
      stage_pay[i]  = fill_pay_q[i];
      if (accept && (cnt_q == 3'(i))) begin
        stage_flag[i] = in__0;
        stage_pay[i]  = in__1;
      end
    end

    fire        = (eff_cnt == 3'd4) || (flush_req && (eff_cnt != 3'd0));
    cnt_d       = eff_cnt;
    fill_flag_d = stage_flag;
    fill_pay_d  = stage_pay;
    out_flag_d  = out_flag_q;
    out_pay_d   = out_pay_q;
    out_valid_d = out_valid_q && !out_ready;
`ifdef PACKER_FLUSH_EN
    out_cnt_d    = out_cnt_q;
    flush_pend_d = flush_req && (eff_cnt != 3'd0);
`endif

    if (fire && out_free) begin
      cnt_d       = 3'd0;
      out_valid_d = 1'b1;
      for (int i = 0; i < 4; i++) begin
        out_flag_d[i] = (3'(i) < eff_cnt) ? stage_flag[i] : 1'b0;
        out_pay_d[i]  = (3'(i) < eff_cnt) ? stage_pay[i] : '0;
      end
`ifdef PACKER_FLUSH_EN
      out_cnt_d    = eff_cnt;
      flush_pend_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q       <= 3'd0;
      fill_flag_q <= '0;
      out_flag_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        fill_pay_q[i] <= '0;
        out_pay_q[i]  <= '0;
      end
`ifdef PACKER_FLUSH_EN
      flush_pend_q <= 1'b0;
      out_cnt_q    <= 3'd0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      fill_flag_q <= fill_flag_d;
      out_flag_q  <= out_flag_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 4; i++) begin
        fill_pay_q[i] <= fill_pay_d[i];
        out_pay_q[i]  <= out_pay_d[i];
      end
`ifdef PACKER_FLUSH_EN
      flush_pend_q <= flush_pend_d;
      out_cnt_q    <= out_cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_0__0  = out_flag_q[0];
  assign out_0__1  = out_pay_q[0];
  assign out_1__0  = out_flag_q[1];
  assign out_1__1  = out_pay_q[1];
  assign out_2__0  = out_flag_q[2];
  assign out_2__1  = out_pay_q[2];
  assign out_3__0  = out_flag_q[3];
  assign out_3__1  = out_pay_q[3];

endmodule

// File: tb/tb_elem_array_packer.sv
// Self-checking bench for elem_array_packer: directed scenarios plus a randomized
// tuple-queue scoreboard. Flush scenarios run only when PACKER_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_elem_array_packer;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in__0 = 1'b0;
  logic [1:0] in__1 = 2'b00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_0__0, out_1__0, out_2__0, out_3__0;
  logic [1:0] out_0__1, out_1__1, out_2__1, out_3__1;
  logic       flush_drv = 1'b0;
`ifdef PACKER_FLUSH_EN
  logic       flush = 1'b0;
  logic [2:0] out_cnt;
  logic [2:0] s_out_cnt;
`endif

  logic [11:0] out_vec;
  logic [11:0] s_vec, prev_vec;
  logic        s_in_ready, s_out_valid, prev_hold;
  logic [2:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign out_vec = {out_3__0, out_3__1, out_2__0, out_2__1,
                    out_1__0, out_1__1, out_0__0, out_0__1};

  elem_array_packer #(.DATA_W(2)) dut (
    .clk(clk), .arst(arst),
    .in_valid(in_valid), .in_ready(in_ready), .in__0(in__0), .in__1(in__1),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef PACKER_FLUSH_EN
    .flush(flush), .out_cnt(out_cnt),
`endif
    .out_0__0(out_0__0), .out_0__1(out_0__1), .out_1__0(out_1__0), .out_1__1(out_1__1),
    .out_2__0(out_2__0), .out_2__1(out_2__1), .out_3__0(out_3__0), .out_3__1(out_3__1)
  );

  // One clock of stimulus; samples pre-edge state and runs the tuple scoreboard.
  task automatic cycle(input logic iv, input logic [2:0] tup, input logic ordy);
    int n;
    logic [2:0] e, g;
    @(negedge clk);
    in_valid = iv; in__0 = tup[2]; in__1 = tup[1:0]; out_ready = ordy;
`ifdef PACKER_FLUSH_EN
    flush = flush_drv;
`endif
    #1;
    s_in_ready = in_ready; s_out_valid = out_valid; s_vec = out_vec;
`ifdef PACKER_FLUSH_EN
    s_out_cnt = out_cnt;
`endif
    if (prev_hold) begin
      checks++;
      if (!out_valid || out_vec !== prev_vec) begin
        errors++;
        $display("FAIL hold_stable: got valid=%b data=%h, need valid=1 data=%h", out_valid, out_vec, prev_vec);
      end
    end
    prev_hold = out_valid && !ordy;
    prev_vec  = out_vec;
    if (out_valid && ordy) begin
      n = 4;
`ifdef PACKER_FLUSH_EN
      n = (exp_q.size() < 4) ? exp_q.size() : 4;
      checks++;
      if (out_cnt !== 3'(n)) begin
        errors++;
        $display("FAIL out_cnt: got %0d, need %0d", out_cnt, n);
      end
`endif
      checks++;
      if (n == 0 || exp_q.size() < n) begin
        errors++;
        $display("FAIL group_avail: got output group, model holds %0d tuples", exp_q.size());
      end else begin
        for (int k = 0; k < 4; k++) begin
          e = (k < n) ? exp_q.pop_front() : 3'b000;
          g = out_vec[k*3 +: 3];
          checks++;
          if (g !== e) begin
            errors++;
            $display("FAIL element_%0d: got %b, need %b", k, g, e);
          end
        end
      end
    end
    if (iv && in_ready) exp_q.push_back(tup);
    @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_vec !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h, need 0 0 000", in_ready, out_valid, out_vec);
    end
    arst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, need 1", in_ready);
    end
    prev_hold = 1'b0;
  endtask

  task automatic test_single_group();
    logic [2:0] t [4];
    t[0] = 3'b100; t[1] = 3'b001; t[2] = 3'b110; t[3] = 3'b011;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, t[i], 1'b1);
      checks++;
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL single_fill_%0d: got vld=%b rdy=%b, need 0 1", i, s_out_valid, s_in_ready);
      end
    end
    cycle(1'b0, 3'b000, 1'b1);
    checks++;
    if (s_out_valid !== 1'b1 || s_vec !== {3'b011, 3'b110, 3'b001, 3'b100}) begin
      errors++;
      $display("FAIL single_group: got vld=%b data=%h, need 1 %h", s_out_valid, s_vec, {3'b011, 3'b110, 3'b001, 3'b100});
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) cycle(1'b1, 3'($urandom_range(0, 7)), 1'b1);
      else        cycle(1'b0, 3'b000, 1'b1);
      exp_v = (i == 4) || (i == 8) || (i == 12);
      checks++;
      if (s_out_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid_cyc%0d: got %b, need %b", i, s_out_valid, exp_v);
      end
      if (i < 12) begin
        checks++;
        if (s_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_cyc%0d: got %b, need 1", i, s_in_ready);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  t [8];
    logic [11:0] g1, g2;
    int idx = 0;
    for (int i = 0; i < 8; i++) t[i] = 3'($urandom_range(0, 7));
    g1 = {t[3], t[2], t[1], t[0]};
    g2 = {t[7], t[6], t[5], t[4]};
    for (int c = 0; c < 20 && idx < 8; c++) begin
      cycle(1'b1, t[idx], 1'b0);
      if (s_in_ready) idx++;
    end
    checks++;
    if (idx != 8) begin
      errors++;
      $display("FAIL bp_accept_count: got %0d, need 8", idx);
    end
    cycle(1'b0, 3'b000, 1'b0);
    checks++;
    if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_vec !== g1) begin
      errors++;
      $display("FAIL bp_hold: got rdy=%b vld=%b data=%h, need 0 1 %h", s_in_ready, s_out_valid, s_vec, g1);
    end
    cycle(1'b0, 3'b000, 1'b1);
    cycle(1'b0, 3'b000, 1'b1);
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b1 || s_vec !== g2) begin
      errors++;
      $display("FAIL bp_group2: got rdy=%b vld=%b data=%h, need 1 1 %h", s_in_ready, s_out_valid, s_vec, g2);
    end
  endtask

  task automatic test_reset_mid_group();
    logic [2:0] t [4];
    for (int i = 0; i < 6; i++) cycle(1'b1, 3'($urandom_range(0, 7)), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_vec !== 12'h000) begin
      errors++;
      $display("FAIL midreset_state: got rdy=%b vld=%b data=%h, need 0 0 000", in_ready, out_valid, out_vec);
    end
    #1 arst = 1'b0;
    exp_q.delete();
    prev_hold = 1'b0;
    for (int i = 0; i < 4; i++) t[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, t[i], 1'b1);
      checks++;
      if (s_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_partial_%0d: got vld=%b, need 0", i, s_out_valid);
      end
    end
    cycle(1'b0, 3'b000, 1'b1);
    checks++;
    if (s_out_valid !== 1'b1 || s_vec !== {t[3], t[2], t[1], t[0]}) begin
      errors++;
      $display("FAIL midreset_group: got vld=%b data=%h, need 1 %h", s_out_valid, s_vec, {t[3], t[2], t[1], t[0]});
    end
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush();
    cycle(1'b1, 3'b101, 1'b1);
    cycle(1'b1, 3'b110, 1'b1);
    cycle(1'b1, 3'b111, 1'b1);
    flush_drv = 1'b1;
    cycle(1'b0, 3'b000, 1'b1);
    flush_drv = 1'b0;
    cycle(1'b0, 3'b000, 1'b1);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_cnt !== 3'd3 || s_vec !== {3'b000, 3'b111, 3'b110, 3'b101}) begin
      errors++;
      $display("FAIL flush_partial: got vld=%b cnt=%0d data=%h, need 1 3 %h", s_out_valid, s_out_cnt, s_vec, {3'b000, 3'b111, 3'b110, 3'b101});
    end
    flush_drv = 1'b1;
    cycle(1'b0, 3'b000, 1'b1);
    flush_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 3'b000, 1'b1);
      checks++;
      if (s_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_empty_%0d: got vld=%b, need 0", i, s_out_valid);
      end
    end
  endtask
`endif

  task automatic test_random();
    int accepted = 0;
    logic iv;
    for (int c = 0; c < 60000 && accepted < 10000; c++) begin
      iv = 1'($urandom_range(0, 1));
      cycle(iv, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (iv && s_in_ready) accepted++;
    end
    checks++;
    if (accepted != 10000) begin
      errors++;
      $display("FAIL random_accepted: got %0d, need 10000", accepted);
    end
    repeat (4) cycle(1'b0, 3'b000, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_leftover: got %0d tuples undelivered, need 0", exp_q.size());
    end
  endtask

  initial begin
    prev_hold = 1'b0;
    prev_vec  = '0;
    test_reset();
    test_single_group();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_group();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
